// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// the zero-register index and the default mul/div latency.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_LATENCY_DEF = 4;

endpackage

// File: rtl/hazard_perf_ctr.sv
// Single 32-bit event counter that holds at all-ones instead of wrapping.
// RESET_VAL lets a counter start at an arbitrary value after rst.
module hazard_perf_ctr #(
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  output logic [31:0] o_cnt
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= RESET_VAL;
    else if (i_inc && (r_cnt != 32'hFFFF_FFFF))
      r_cnt <= r_cnt + 32'd1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for IF/ID and ID/EX: load-use bubbles, taken-branch
// flushes and multi-cycle mul/div stalls. Define HAZARD_PERF_EN for perf counters.
//
// state   | meaning
// RUN     | normal flow; branch flush, mul/div entry or load-use bubble as needed
// MD_WAIT | front end frozen while the mul/div finishes; EX holds bubbles
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int MD_CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_dest,
  input  logic       ex_regwrite,
  input  logic       ex_branch_taken,
  input  logic       ex_md_start,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       md_busy,
  output logic [1:0] state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_luse_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_md_cnt
`endif
);

  hz_state_t           r_state, w_state_nxt;
  logic [MD_CNT_W-1:0] r_md_cnt, w_md_cnt_nxt;
  logic                w_luse;

  assign w_luse = ex_memread && ex_regwrite && (ex_dest != REG_ZERO) &&
                  ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    md_busy      = 1'b0;
    case (r_state)
      RUN: begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (ex_md_start) begin
          // The start cycle is the first of MD_LATENCY stall cycles.
          w_state_nxt  = MD_WAIT;
          w_md_cnt_nxt = MD_CNT_W'(MD_LATENCY - 1);
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_flush   = 1'b1;
          md_busy      = 1'b1;
        end else if (w_luse) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end
      MD_WAIT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        md_busy    = 1'b1;
        if (r_md_cnt <= MD_CNT_W'(1)) begin
          w_state_nxt  = RUN;
          w_md_cnt_nxt = '0;
        end else begin
          w_md_cnt_nxt = r_md_cnt - MD_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt  = RUN;
        w_md_cnt_nxt = '0;
      end
    endcase
  end

  assign state_o = r_state;

`ifdef HAZARD_PERF_EN
  logic w_luse_stall, w_br_flush;

  assign w_luse_stall = (r_state == RUN) && !ex_branch_taken && !ex_md_start && w_luse;
  assign w_br_flush   = (r_state == RUN) && ex_branch_taken;

  hazard_perf_ctr u_perf_luse (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_luse_stall),
    .o_cnt (perf_luse_cnt)
  );

  hazard_perf_ctr u_perf_flush (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_br_flush),
    .o_cnt (perf_flush_cnt)
  );

  hazard_perf_ctr u_perf_md (
    .clk   (clk),
    .rst   (rst),
    .i_inc (md_busy),
    .o_cnt (perf_md_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl plus a standalone saturating-counter check.
// Perf-counter totals are checked only when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_dest;
  logic       id_uses_rt, ex_memread, ex_regwrite, ex_branch_taken, ex_md_start;
  logic       pc_write, ifid_write, ifid_flush, idex_flush, md_busy;
  logic [1:0] state_o;
  logic       sat_inc;
  logic [31:0] sat_cnt;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_luse, perf_flush, perf_md;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // {pc_write, ifid_write, ifid_flush, idex_flush, md_busy, state_o}
  localparam logic [6:0] PASS   = 7'b11000_00;
  localparam logic [6:0] STALL  = 7'b00010_00;
  localparam logic [6:0] FLUSH  = 7'b11110_00;
  localparam logic [6:0] MDRUN  = 7'b00011_00;
  localparam logic [6:0] MDWAIT = 7'b00011_01;

  logic [6:0] obs;
  assign obs = {pc_write, ifid_write, ifid_flush, idex_flush, md_busy, state_o};

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(4), .MD_CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_memread      (ex_memread),
    .ex_dest         (ex_dest),
    .ex_regwrite     (ex_regwrite),
    .ex_branch_taken (ex_branch_taken),
    .ex_md_start     (ex_md_start),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .md_busy         (md_busy),
    .state_o         (state_o)
`ifdef HAZARD_PERF_EN
    ,
    .perf_luse_cnt   (perf_luse),
    .perf_flush_cnt  (perf_flush),
    .perf_md_cnt     (perf_md)
`endif
  );

  hazard_perf_ctr #(.RESET_VAL(32'hFFFF_FFFD)) u_sat (
    .clk   (clk),
    .rst   (rst),
    .i_inc (sat_inc),
    .o_cnt (sat_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    #1;
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_dest = 5'd0;
    ex_branch_taken = 1'b0; ex_md_start = 1'b0;
  endtask

  task automatic set_luse();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dest = 5'd8; id_rs = 5'd8;
  endtask

  initial begin
    rst = 1'b1; sat_inc = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0;
    chk("reset_outputs", PASS);
    chk32("sat_reset", sat_cnt, 32'hFFFF_FFFD);

    // Load-use on Rs: one bubble, then pass-through when the load leaves EX
    set_luse();
    chk("luse_rs", STALL);
    tick();
    ex_memread = 1'b0;
    chk("luse_rs_after", PASS);

    // Rt match only stalls when Rt is actually read
    idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dest = 5'd9; id_rt = 5'd9; id_rs = 5'd3;
    chk("rt_unused", PASS);
    id_uses_rt = 1'b1;
    chk("rt_used", STALL);
    ex_dest = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    chk("dest_zero", PASS);
    ex_regwrite = 1'b0; ex_dest = 5'd8; id_rs = 5'd8;
    chk("no_regwrite", PASS);

    // Branch has priority over load-use
    idle(); set_luse(); ex_branch_taken = 1'b1;
    chk("branch_over_luse", FLUSH);
    tick();
    idle();
    chk("branch_after", PASS);

    // Mul/div: 4 stall cycles, luse and branch during the wait add nothing
    set_luse(); ex_md_start = 1'b1;
    chk("md_start_over_luse", MDRUN);
    tick();
    ex_md_start = 1'b0;
    chk("md_wait1", MDWAIT);
    tick();
    ex_branch_taken = 1'b1;
    chk("md_wait2_branch", MDWAIT);
    tick();
    ex_branch_taken = 1'b0;
    chk("md_wait3", MDWAIT);
    tick();
    idle();
    chk("md_done", PASS);

    // Reset during the second MD_WAIT cycle
    ex_md_start = 1'b1;
    chk("md2_start", MDRUN);
    tick();
    ex_md_start = 1'b0;
    chk("md2_wait1", MDWAIT);
    tick();
    rst = 1'b1;
    chk("md2_wait2_rst", MDWAIT);
    tick();
    rst = 1'b0;
    chk("after_mid_rst", PASS);
    ex_md_start = 1'b1;
    chk("md3_start", MDRUN);
    tick();
    ex_md_start = 1'b0;
    chk("md3_wait1", MDWAIT);
    tick();
    chk("md3_wait2", MDWAIT);
    tick();
    chk("md3_wait3", MDWAIT);
    tick();
    chk("md3_done", PASS);

    // Saturating counter holds at all-ones
    sat_inc = 1'b1;
    repeat (4) tick();
    sat_inc = 1'b0;
    chk32("sat_hold", sat_cnt, 32'hFFFF_FFFF);

`ifdef HAZARD_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    repeat (3) begin
      set_luse();
      tick();
      idle();
      tick();
    end
    ex_branch_taken = 1'b1;
    repeat (2) tick();
    ex_branch_taken = 1'b0;
    ex_md_start = 1'b1;
    tick();
    ex_md_start = 1'b0;
    repeat (4) tick();
    chk32("perf_luse", perf_luse, 32'd3);
    chk32("perf_flush", perf_flush, 32'd2);
    chk32("perf_md", perf_md, 32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
